// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request/response bundle between the two producers (A: ALU, B: load/multi-cycle)
// and the register-file write port arbiter.
interface regfile_wb_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        b_valid;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        b_ready;
  logic        a_hold;
  logic        EnableWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] pending_mask;
  logic        hold_violation;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  b_ready, a_hold, EnableWrite, write_reg, write_data, pending_mask, hold_violation
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output b_ready, a_hold, EnableWrite, write_reg, write_data, pending_mask, hold_violation
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: A has priority, B is queued in a 2-entry FIFO with
// WAW squashing, starvation relief via a one-cycle a_hold pulse, and a sticky hold violation flag.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [4:0]    reg_q [2];
  logic [4:0]    reg_d [2];
  logic [31:0]   data_q [2];
  logic [31:0]   data_d [2];
  logic [1:0]    vld_q, vld_d;
  logic [1:0]    cnt_q, cnt_d, cnt_p;
  logic [CW-1:0] starve_q, starve_d;
  logic          hold_q, hold_d;
  logic          viol_q, viol_d;
  logic          en_q, en_d;
  logic [4:0]    wreg_q, wreg_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          push, pop, head_vld, b_grant;
  logic [31:0]   mask;

  assign bus.b_ready        = (cnt_q < 2'd2) && !rst;
  assign bus.a_hold         = hold_q;
  assign bus.hold_violation = viol_q;
  assign bus.EnableWrite    = en_q;
  assign bus.write_reg      = wreg_q;
  assign bus.write_data     = wdata_q;
  assign bus.pending_mask   = mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < 2; i++)
      if (vld_q[i]) mask[reg_q[i]] = 1'b1;
  end

  always_comb begin
    push     = bus.b_valid && bus.b_ready;
    head_vld = (cnt_q != 2'd0) && vld_q[0];
    // A squashed head leaves regardless of A; a valid head leaves only when it wins.
    pop      = (cnt_q != 2'd0) && (!vld_q[0] || !bus.a_valid);
    b_grant  = head_vld && !bus.a_valid;

    reg_d  = reg_q;
    data_d = data_q;
    vld_d  = vld_q;
    if (pop) begin
      reg_d[0]  = reg_q[1];
      data_d[0] = data_q[1];
      vld_d     = {1'b0, vld_q[1]};
    end
    cnt_p = cnt_q - {1'b0, pop};
    if (push) begin
      reg_d[cnt_p[0]]  = bus.b_reg;
      data_d[cnt_p[0]] = bus.b_data;
      vld_d[cnt_p[0]]  = 1'b1;
    end
    cnt_d = cnt_p + {1'b0, push};

    // The A value is younger than anything queued, so older writes to its register die here.
    if (bus.a_valid)
      for (int i = 0; i < 2; i++)
        if (reg_d[i] == bus.a_reg) vld_d[i] = 1'b0;

    en_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (bus.a_valid) begin
      if (bus.a_reg != 5'd0) begin
        en_d    = 1'b1;
        wreg_d  = bus.a_reg;
        wdata_d = bus.a_data;
      end
    end else if (b_grant && reg_q[0] != 5'd0) begin
      en_d    = 1'b1;
      wreg_d  = reg_q[0];
      wdata_d = data_q[0];
    end

    if (b_grant || cnt_q == 2'd0) starve_d = '0;
    else if (head_vld && bus.a_valid) starve_d = starve_q + 1'b1;
    else starve_d = starve_q;
    hold_d = 1'b0;
    if (starve_d == CW'(STARVE_LIMIT)) begin
      hold_d   = 1'b1;
      starve_d = '0;
    end

    viol_d = viol_q | (bus.a_valid && hold_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
      vld_q    <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      hold_q   <= 1'b0;
      viol_q   <= 1'b0;
      en_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      reg_q    <= reg_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      hold_q   <= hold_d;
      viol_q   <= viol_d;
      en_q     <= en_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;
  localparam int LIMIT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus();
  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    bit          v;
  } ent_t;

  ent_t        q[$];
  bit          m_en, m_hold, m_viol;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  int          m_cnt;
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_en = 0; m_hold = 0; m_viol = 0; m_wreg = '0; m_wdata = '0; m_cnt = 0;
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) if (q[i].v) m[q[i].r] = 1'b1;
    return m;
  endfunction

  task automatic check_all();
    chk("b_ready", {31'd0, bus.b_ready}, {31'd0, (q.size() < 2) && !rst});
    chk("pending_mask", bus.pending_mask, model_mask());
    chk("a_hold", {31'd0, bus.a_hold}, {31'd0, m_hold});
    chk("hold_violation", {31'd0, bus.hold_violation}, {31'd0, m_viol});
    chk("EnableWrite", {31'd0, bus.EnableWrite}, {31'd0, m_en});
    chk("write_reg", {27'd0, bus.write_reg}, {27'd0, m_wreg});
    chk("write_data", bus.write_data, m_wdata);
  endtask

  // One clock of the reference behaviour, using the inputs currently on the bus.
  task automatic model_step();
    bit   av, push, hv, empty, bg;
    ent_t h;
    av    = bus.a_valid;
    push  = bus.b_valid && (q.size() < 2);
    empty = (q.size() == 0);
    hv    = !empty && q[0].v;
    bg    = 0;
    m_viol = m_viol | (av && m_hold);
    m_en  = 0;
    if (!empty && !q[0].v) void'(q.pop_front());
    else if (!empty && !av) begin
      h  = q.pop_front();
      bg = 1;
      if (h.r != 0) begin m_en = 1; m_wreg = h.r; m_wdata = h.d; end
    end
    if (push) q.push_back('{bus.b_reg, bus.b_data, 1'b1});
    if (av) begin
      foreach (q[i]) if (q[i].r == bus.a_reg) q[i].v = 0;
      if (bus.a_reg != 0) begin m_en = 1; m_wreg = bus.a_reg; m_wdata = bus.a_data; end
    end
    if (bg || empty) m_cnt = 0;
    else if (hv && av) m_cnt++;
    if (m_cnt == LIMIT) begin m_hold = 1; m_cnt = 0; end
    else m_hold = 0;
  endtask

  task automatic cyc(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                     input bit bv, input logic [4:0] br, input logic [31:0] bd);
    @(negedge clk);
    bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
    bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
    #1 check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.a_valid = 0; bus.b_valid = 0;
    rst = 1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    #1 check_all();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    bus.a_valid = 0; bus.a_reg = '0; bus.a_data = '0;
    bus.b_valid = 0; bus.b_reg = '0; bus.b_data = '0;
    model_reset();
    @(negedge clk);
    #1 check_all();
    rst = 0;

    // Solo A, then solo B written one cycle after its push.
    cyc(1, 5, 32'h11, 0, 0, 0);
    chk("solo_a_en", {31'd0, bus.EnableWrite}, 32'd1);
    chk("solo_a_reg", {27'd0, bus.write_reg}, 32'd5);
    chk("solo_a_data", bus.write_data, 32'h11);
    cyc(0, 0, 0, 1, 6, 32'h22);
    chk("solo_b_push_no_write", {31'd0, bus.EnableWrite}, 32'd0);
    idle();
    chk("solo_b_reg", {27'd0, bus.write_reg}, 32'd6);
    chk("solo_b_data", bus.write_data, 32'h22);

    // Collision: A first, B next cycle.
    cyc(1, 3, 32'h33, 1, 4, 32'h44);
    chk("coll_a_reg", {27'd0, bus.write_reg}, 32'd3);
    chk("coll_pending4", {31'd0, bus.pending_mask[4]}, 32'd1);
    idle();
    chk("coll_b_reg", {27'd0, bus.write_reg}, 32'd4);
    chk("coll_pending_clear", bus.pending_mask, 32'd0);

    // WAW squash.
    cyc(0, 0, 0, 1, 7, 32'h77);
    cyc(1, 7, 32'hA7, 0, 0, 0);
    chk("waw_data", bus.write_data, 32'hA7);
    chk("waw_pending7", {31'd0, bus.pending_mask[7]}, 32'd0);
    idle();
    chk("waw_no_stale", {31'd0, bus.EnableWrite}, 32'd0);

    // Starvation relief, then a violation during the hold.
    cyc(0, 0, 0, 1, 9, 32'h99);
    cyc(1, 1, 32'h1, 0, 0, 0);
    cyc(1, 2, 32'h2, 0, 0, 0);
    cyc(1, 3, 32'h3, 0, 0, 0);
    chk("starve_hold", {31'd0, bus.a_hold}, 32'd1);
    idle();
    chk("starve_b_reg", {27'd0, bus.write_reg}, 32'd9);
    chk("starve_hold_drop", {31'd0, bus.a_hold}, 32'd0);
    cyc(0, 0, 0, 1, 10, 32'hAA);
    cyc(1, 1, 32'h1, 0, 0, 0);
    cyc(1, 2, 32'h2, 0, 0, 0);
    cyc(1, 3, 32'h3, 0, 0, 0);
    cyc(1, 4, 32'h4, 0, 0, 0);
    chk("viol_flag", {31'd0, bus.hold_violation}, 32'd1);
    chk("viol_a_granted", {27'd0, bus.write_reg}, 32'd4);
    idle();
    idle();

    // Full FIFO and register zero.
    cyc(1, 1, 32'h1, 1, 11, 32'hB1);
    cyc(1, 2, 32'h2, 1, 12, 32'hB2);
    chk("full_b_ready", {31'd0, bus.b_ready}, 32'd0);
    cyc(1, 3, 32'h3, 1, 13, 32'hB3);
    idle();
    idle();
    idle();
    cyc(0, 0, 0, 1, 0, 32'hDEAD);
    idle();
    chk("zero_no_write", {31'd0, bus.EnableWrite}, 32'd0);
    chk("zero_popped", {31'd0, bus.b_ready}, 32'd1);

    // Reset with two entries queued.
    cyc(1, 1, 32'h1, 1, 20, 32'hC0);
    cyc(1, 2, 32'h2, 1, 21, 32'hC1);
    pulse_reset();
    idle();
    chk("post_reset_no_write", {31'd0, bus.EnableWrite}, 32'd0);
    chk("post_reset_mask", bus.pending_mask, 32'd0);

    // Randomized traffic with a small register range to provoke collisions and squashes.
    for (int n = 0; n < 400; n++) begin
      bit av;
      av = ($urandom_range(0, 2) == 0) && (!bus.a_hold || $urandom_range(0, 7) == 0);
      cyc(av, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      if (n == 200) pulse_reset();
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
